// File: rtl/param_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : param_sync_fifo                                              |
// | Description : Parametrised single-clock FIFO with occupancy count,         |
// |               programmable almost-full / almost-empty flags and            |
// |               one-cycle overflow / underflow error pulses.                 |
// | Option      : FIFO_FWFT_EN - when defined, first-word-fall-through mode:   |
// |               data_out shows the head word combinationally while !empty    |
// |               (0 while empty) and rd_en acts as a pop acknowledge.         |
// | Ports       : clk, rst (sync, active-high)                                 |
// |               wr_en, data_in[WIDTH]      - write side                      |
// |               rd_en, data_out[WIDTH]     - read side                       |
// |               full, empty, almost_full, almost_empty - count decodes       |
// |               count[$clog2(DEPTH+1)]     - occupancy 0..DEPTH              |
// |               overflow, underflow        - rejected write / read pulses    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module param_sync_fifo #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = 3,
   parameter int AE_LEVEL = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             rd_accept;
   logic             wr_accept;

   // Flags decode the registered count, so they track it in the same cycle.
   assign full         = (count == CW'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (count >= CW'(AF_LEVEL));
   assign almost_empty = (count <= CW'(AE_LEVEL));

   // A write into a full FIFO is still accepted when a read frees the slot
   // on the same edge.
   assign rd_accept = rd_en && !empty;
   assign wr_accept = wr_en && (!full || rd_accept);

   // Storage is intentionally not reset; writes are suppressed during reset.
   always_ff @(posedge clk) begin
      if (!rst && wr_accept)
         mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= wr_en && !wr_accept;
         underflow <= rd_en && !rd_accept;
         if (wr_accept)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_accept)
            rd_ptr <= rd_ptr + AW'(1);
         case ({wr_accept, rd_accept})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef FIFO_FWFT_EN
   // Head word falls through; zero while nothing is stored.
   assign data_out = empty ? '0 : mem[rd_ptr];
`else
   // One-cycle read latency; holds the last popped word otherwise.
   always_ff @(posedge clk) begin
      if (rst)
         data_out <= '0;
      else if (rd_accept)
         data_out <= mem[rd_ptr];
   end
`endif

endmodule
`default_nettype wire
